serial_word_loader: RTL

//   Serial-in, parallel-out deserializer that sits directly upstream of the
//   N-bit register stage. It collects N serial bits and presents the assembled

---
 rtl/serial_word_loader_if.sv | 23 ++
 rtl/serial_word_loader.sv | 102 ++++++++++
 2 files changed

// File: rtl/serial_word_loader_if.sv
// Handshake bundle between a serial bit source, the word loader and the
// downstream register stage that consumes assembled words.
interface serial_word_loader_if #(
  parameter int N = 4
);
  logic         s_bit;
  logic         s_valid;
  logic         s_ready;
  logic         s_clear;
  logic [N-1:0] q_data;
  logic         q_valid;
  logic         q_ready;

  modport master (
    output s_bit, s_valid, s_clear, q_ready,
    input  s_ready, q_data, q_valid
  );

  modport slave (
    input  s_bit, s_valid, s_clear, q_ready,
    output s_ready, q_data, q_valid
  );
endinterface

// File: rtl/serial_word_loader.sv
// Serial-in, parallel-out word loader with one word of output buffering.
//   state | meaning
//   SHIFT | accepting serial bits into the shift register
//   HOLD  | complete word parked in sr, waiting for the output slot to free
module serial_word_loader #(
  parameter int N         = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input logic                CLK,
  input logic                RST_N,
  serial_word_loader_if.slave bus
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {
    SHIFT = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [N-1:0]    r_sr, w_sr_nxt;
  logic [N-1:0]    r_q_data, w_q_data_nxt;
  logic [N-1:0]    w_shifted;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;
  logic            r_q_valid, w_q_valid_nxt;
  logic            w_accept;
  logic            w_take;
  logic            w_last;

  generate
    if (N == 1) begin : g_single
      assign w_shifted = bus.s_bit;
    end else if (MSB_FIRST) begin : g_msb
      assign w_shifted = {r_sr[N-2:0], bus.s_bit};
    end else begin : g_lsb
      assign w_shifted = {bus.s_bit, r_sr[N-1:1]};
    end
  endgenerate

  assign bus.s_ready = RST_N && (r_state == SHIFT);
  assign bus.q_data  = r_q_data;
  assign bus.q_valid = r_q_valid;

  assign w_accept = bus.s_valid && bus.s_ready;
  assign w_take   = r_q_valid && bus.q_ready;
  assign w_last   = (r_cnt == CW'(N - 1));

  always_comb begin
    w_state_nxt   = r_state;
    w_sr_nxt      = r_sr;
    w_cnt_nxt     = r_cnt;
    w_q_data_nxt  = r_q_data;
    w_q_valid_nxt = r_q_valid;

    if (bus.s_clear) begin
      // Abort drops the partial or parked word but lets the output handshake finish.
      w_cnt_nxt   = '0;
      w_state_nxt = SHIFT;
      if (w_take) w_q_valid_nxt = 1'b0;
    end else if (r_state == HOLD) begin
      if (bus.q_ready) begin
        w_q_data_nxt = r_sr;
        w_state_nxt  = SHIFT;
      end
    end else begin
      if (w_take) w_q_valid_nxt = 1'b0;
      if (w_accept) begin
        if (w_last) begin
          w_cnt_nxt = '0;
          if (!r_q_valid || bus.q_ready) begin
            w_q_data_nxt  = w_shifted;
            w_q_valid_nxt = 1'b1;
          end else begin
            w_sr_nxt    = w_shifted;
            w_state_nxt = HOLD;
          end
        end else begin
          w_sr_nxt  = w_shifted;
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_state   <= SHIFT;
      r_sr      <= '0;
      r_cnt     <= '0;
      r_q_data  <= '0;
      r_q_valid <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_sr      <= w_sr_nxt;
      r_cnt     <= w_cnt_nxt;
      r_q_data  <= w_q_data_nxt;
      r_q_valid <= w_q_valid_nxt;
    end
  end

endmodule
